// File: rtl/pixel_unpacker_pkg.sv
// Shared definitions for the packed 24-bit-over-32-bit video stream:
// phase encoding of the 4-pixels-per-3-words cycle, default frame
// geometry and the byte order used by both packer and unpacker.
package pixel_unpacker_pkg;

    // Position within the 3-word / 4-pixel packing cycle
    typedef enum logic [1:0] {
        PH0,
        PH1,
        PH2,
        PH3
    } phase_t;

    localparam int unsigned DEF_X_SIZE = 640;
    localparam int unsigned DEF_Y_SIZE = 480;

    // Pixel = {r,g,b}, blue in the lowest byte
    localparam int unsigned B_LSB = 0;
    localparam int unsigned G_LSB = 8;
    localparam int unsigned R_LSB = 16;

    function automatic logic [23:0] pack_rgb(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/pixel_unpacker_if.sv
// Packed AXI-Stream input plus unpacked pixel output of pixel_unpacker.
// slave: the unpacker side; master: the producer/consumer surrounding it.
interface pixel_unpacker_if;
    logic [31:0] in_stream_tdata;
    logic [3:0]  in_stream_tkeep;
    logic        in_stream_tuser;
    logic        in_stream_tlast;
    logic        in_stream_tvalid;
    logic        in_stream_tready;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [9:0]  x_out;
    logic [8:0]  y_out;
    logic        sof;
    logic        eol;
    logic        pix_valid;
    logic        pix_ready;

    modport slave (
        input  in_stream_tdata, in_stream_tkeep, in_stream_tuser,
               in_stream_tlast, in_stream_tvalid, pix_ready,
        output in_stream_tready, r, g, b, x_out, y_out, sof, eol, pix_valid
    );

    modport master (
        output in_stream_tdata, in_stream_tkeep, in_stream_tuser,
               in_stream_tlast, in_stream_tvalid, pix_ready,
        input  in_stream_tready, r, g, b, x_out, y_out, sof, eol, pix_valid
    );
endinterface

// File: rtl/pixel_unpacker.sv
// pixel_unpacker: turns 32-bit words carrying 24-bit pixels (four pixels
// per three words) into one pixel per cycle with x/y coordinates.
// Build option PIXEL_UNPACKER_CHECK_EN enables SOF/EOL framing checks,
// discard-until-SOF, resynchronisation and the error counter.
module pixel_unpacker
    import pixel_unpacker_pkg::*;
#(
    parameter int unsigned X_SIZE = DEF_X_SIZE,
    parameter int unsigned Y_SIZE = DEF_Y_SIZE
) (
    input  logic            aclk,
    input  logic            reset,
    pixel_unpacker_if.slave bus,
    output logic [15:0]     frame_count,
    output logic [7:0]      err_count
);

    localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
    localparam logic [9:0] X_PEN  = 10'(X_SIZE - 2);
    localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

`ifdef PIXEL_UNPACKER_CHECK_EN
    localparam logic SYNC_AT_RESET = 1'b0;
`else
    localparam logic SYNC_AT_RESET = 1'b1;
`endif

    phase_t      r_phase, w_phase, w_ph;
    logic [23:0] r_res, w_res;
    logic        r_synced, w_synced;
    logic [9:0]  r_x, w_x, w_ex;
    logic [8:0]  r_y, w_y, w_ey;
    logic [23:0] r_pix, w_pix, w_epix;
    logic [9:0]  r_xo, w_xo;
    logic [8:0]  r_yo, w_yo;
    logic        r_sof, w_sof, r_eol, w_eol, r_pv, w_pv;
    logic [15:0] r_frame, w_frame;
    logic [7:0]  r_err, w_err;
    logic        w_out_free, w_acc, w_emit, w_start, w_drop, w_realign, w_err_inc;
    logic        w_exp_user, w_exp_last;
    logic        w_unused;

`ifdef PIXEL_UNPACKER_CHECK_EN
    assign w_unused = ^bus.in_stream_tkeep;
`else
    assign w_unused = ^{bus.in_stream_tkeep, bus.in_stream_tuser, bus.in_stream_tlast};
`endif

    assign w_out_free = !r_pv | bus.pix_ready;
    assign bus.in_stream_tready = reset ? 1'b0 :
                                  (r_synced ? (r_phase != PH3 && w_out_free) : 1'b1);
    assign w_acc      = bus.in_stream_tvalid & bus.in_stream_tready;
    assign w_exp_user = (r_phase == PH0) && (r_x == '0) && (r_y == '0);
    // The PH2 word carries the tail of the PH3 pixel, which ends the line
    assign w_exp_last = (r_phase == PH2) && (r_x == X_PEN);

    // Next-state: phase/residue, framing decisions, pixel counters, output stage
    always_comb begin
        w_phase   = r_phase;
        w_res     = r_res;
        w_synced  = r_synced;
        w_x       = r_x;
        w_y       = r_y;
        w_pix     = r_pix;
        w_xo      = r_xo;
        w_yo      = r_yo;
        w_sof     = r_sof;
        w_eol     = r_eol;
        w_pv      = r_pv;
        w_frame   = r_frame;
        w_err     = r_err;
        w_emit    = 1'b0;
        w_epix    = '0;
        w_ex      = r_x;
        w_ey      = r_y;
        w_ph      = r_phase;
        w_start   = 1'b0;
        w_drop    = 1'b0;
        w_realign = 1'b0;
        w_err_inc = 1'b0;

        if (r_phase == PH3) begin
            if (w_out_free) begin
                w_emit  = 1'b1;
                w_epix  = r_res;
                w_phase = PH0;
            end
        end else if (w_acc) begin
`ifdef PIXEL_UNPACKER_CHECK_EN
            if (!r_synced) begin
                if (bus.in_stream_tuser) begin
                    w_start  = 1'b1;
                    w_synced = 1'b1;
                end else begin
                    w_drop = 1'b1;
                end
            end else if (bus.in_stream_tuser && !w_exp_user) begin
                w_start   = 1'b1;
                w_err_inc = 1'b1;
            end else if (bus.in_stream_tlast && !w_exp_last) begin
                w_err_inc = 1'b1;
                w_realign = 1'b1;
            end else if (!bus.in_stream_tlast && w_exp_last) begin
                w_err_inc = 1'b1;
            end
`endif
            if (w_start) begin
                w_ph = PH0;
                w_ex = '0;
                w_ey = '0;
            end
            if (!w_drop) begin
                w_emit = 1'b1;
                case (w_ph)
                    PH0: begin
                        w_epix  = bus.in_stream_tdata[23:0];
                        w_res   = {16'h0, bus.in_stream_tdata[31:24]};
                        w_phase = PH1;
                    end
                    PH1: begin
                        w_epix  = {bus.in_stream_tdata[15:0], r_res[7:0]};
                        w_res   = {8'h0, bus.in_stream_tdata[31:16]};
                        w_phase = PH2;
                    end
                    default: begin
                        w_epix  = {bus.in_stream_tdata[7:0], r_res[15:0]};
                        w_res   = bus.in_stream_tdata[31:8];
                        w_phase = PH3;
                    end
                endcase
                if (w_realign) begin
                    w_phase = PH0;
                    w_res   = '0;
                end
            end
        end

        if (w_emit) begin
            w_pix = w_epix;
            w_xo  = w_ex;
            w_yo  = w_ey;
            w_sof = (w_ex == '0) && (w_ey == '0);
            w_eol = (w_ex == X_LAST);
            w_pv  = 1'b1;
            if (w_ex == X_LAST) begin
                w_x = '0;
                if (w_ey == Y_LAST) begin
                    w_y     = '0;
                    w_frame = r_frame + 16'd1;
                end else begin
                    w_y = w_ey + 9'd1;
                end
            end else begin
                w_x = w_ex + 10'd1;
            end
            // Early EOL: next word starts a fresh line regardless of position
            if (w_realign) begin
                w_x = '0;
                w_y = (w_ey == Y_LAST) ? '0 : w_ey + 9'd1;
            end
        end else if (bus.pix_ready) begin
            w_pv = 1'b0;
        end

        if (w_err_inc && r_err != 8'hFF) begin
            w_err = r_err + 8'd1;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_phase  <= PH0;
            r_res    <= '0;
            r_synced <= SYNC_AT_RESET;
            r_x      <= '0;
            r_y      <= '0;
            r_pix    <= '0;
            r_xo     <= '0;
            r_yo     <= '0;
            r_sof    <= 1'b0;
            r_eol    <= 1'b0;
            r_pv     <= 1'b0;
            r_frame  <= '0;
            r_err    <= '0;
        end else begin
            r_phase  <= w_phase;
            r_res    <= w_res;
            r_synced <= w_synced;
            r_x      <= w_x;
            r_y      <= w_y;
            r_pix    <= w_pix;
            r_xo     <= w_xo;
            r_yo     <= w_yo;
            r_sof    <= w_sof;
            r_eol    <= w_eol;
            r_pv     <= w_pv;
            r_frame  <= w_frame;
            r_err    <= w_err;
        end
    end

    assign bus.r       = r_pix[R_LSB +: 8];
    assign bus.g       = r_pix[G_LSB +: 8];
    assign bus.b       = r_pix[B_LSB +: 8];
    assign bus.x_out   = r_xo;
    assign bus.y_out   = r_yo;
    assign bus.sof     = r_sof;
    assign bus.eol     = r_eol;
    assign bus.pix_valid = r_pv;
    assign frame_count = r_frame;
    assign err_count   = r_err;

endmodule

// File: tb/tb_pixel_unpacker.sv
// Directed/randomised bench for pixel_unpacker on an 8x4 frame. Expected
// pixels come from a byte-stream model: accepted words are appended to a
// byte queue and pixels are cut three bytes at a time in raster order.
module tb_pixel_unpacker;
    import pixel_unpacker_pkg::*;

    localparam int XS  = 8;
    localparam int YS  = 4;
    localparam int WPL = XS * 3 / 4;
`ifdef PIXEL_UNPACKER_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    typedef struct {
        logic [31:0] d;
        logic        u;
        logic        l;
    } word_t;

    logic        aclk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] frame_count;
    logic [7:0]  err_count;

    pixel_unpacker_if bus();

    pixel_unpacker #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
        .aclk        (aclk),
        .reset       (reset),
        .bus         (bus.slave),
        .frame_count (frame_count),
        .err_count   (err_count)
    );

    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;

    word_t       wq[$];
    word_t       fr[$];
    logic [44:0] expq[$];
    logic [7:0]  bq[$];
    int          mx, my, merr, mframe;
    bit          msynced;
    word_t       idle = '{d: 32'h0, u: 1'b0, l: 1'b0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        expq.delete();
        bq.delete();
        mx = 0;
        my = 0;
        merr = 0;
        mframe = 0;
        msynced = !CHECK;
    endtask

    task automatic model_emit_one();
        logic [23:0] p;
        p = pack_rgb(bq[2], bq[1], bq[0]);
        void'(bq.pop_front());
        void'(bq.pop_front());
        void'(bq.pop_front());
        expq.push_back({p, 10'(mx), 9'(my), (mx == 0 && my == 0), (mx == XS - 1)});
        if (mx == XS - 1) begin
            mx = 0;
            if (my == YS - 1) begin
                my = 0;
                mframe++;
            end else begin
                my++;
            end
        end else begin
            mx++;
        end
    endtask

    task automatic model_word(input word_t w);
        bit realign = 1'b0;
        bit exp_u, exp_l;
        int n, k;
        if (CHECK) begin
            if (!msynced) begin
                if (!w.u) return;
                msynced = 1'b1;
                bq.delete();
                mx = 0;
                my = 0;
            end else begin
                exp_u = (bq.size() == 0) && mx == 0 && my == 0;
                n = bq.size() + 4;
                k = n / 3;
                exp_l = (n % 3 == 0) && (mx + k - 1 == XS - 1);
                if (w.u && !exp_u) begin
                    if (merr < 255) merr++;
                    bq.delete();
                    mx = 0;
                    my = 0;
                end else if (w.l && !exp_l) begin
                    if (merr < 255) merr++;
                    realign = 1'b1;
                end else if (!w.l && exp_l) begin
                    if (merr < 255) merr++;
                end
            end
        end
        for (int i = 0; i < 4; i++) bq.push_back(w.d[8*i +: 8]);
        if (realign) begin
            model_emit_one();
            bq.delete();
            mx = 0;
            my = (my + 1) % YS;
        end else begin
            while (bq.size() >= 3) model_emit_one();
        end
    endtask

    // One clock: drive at the falling edge, then evaluate the handshakes
    // that will complete at the next rising edge.
    task automatic step(input bit v, input word_t w, input bit pr, input bit rst);
        int pending;
        @(negedge aclk);
        reset = rst;
        bus.in_stream_tvalid = v;
        bus.in_stream_tdata  = w.d;
        bus.in_stream_tuser  = w.u;
        bus.in_stream_tlast  = w.l;
        bus.in_stream_tkeep  = 4'hF;
        bus.pix_ready        = pr;
        #1;
        if (rst) begin
            model_reset();
        end else begin
            pending = expq.size() - int'(bus.pix_valid);
            if (msynced && pending > 0) chk("tready_ph3", 64'(bus.in_stream_tready), 64'd0);
            if (bus.pix_valid && pr) begin
                chk("pix_extra", 64'(expq.size() != 0), 64'd1);
                if (expq.size() != 0) begin
                    chk("pixel", 64'({bus.r, bus.g, bus.b, bus.x_out, bus.y_out, bus.sof, bus.eol}),
                        64'(expq[0]));
                    void'(expq.pop_front());
                end
            end
            if (v && bus.in_stream_tready) model_word(w);
        end
    endtask

    task automatic check_zero(input string tag);
        @(negedge aclk);
        #1;
        chk(tag, {bus.r, bus.g, bus.b, bus.x_out, bus.y_out, bus.sof, bus.eol, bus.pix_valid,
                  bus.in_stream_tready, frame_count, err_count}, 64'd0);
    endtask

    task automatic send(input int gap_pct, input int stall_pct);
        int cyc = 0;
        bit v, pr, acc;
        while (wq.size() > 0 && cyc < 4000) begin
            v  = ($urandom_range(0, 99) >= gap_pct);
            pr = ($urandom_range(0, 99) >= stall_pct);
            step(v, wq[0], pr, 1'b0);
            acc = v && bus.in_stream_tready;
            if (acc) void'(wq.pop_front());
            cyc++;
        end
        chk("send_timeout", 64'(wq.size()), 64'd0);
        wq.delete();
    endtask

    task automatic drain_and_check(input string tag);
        int cyc = 0;
        while (expq.size() > 0 && cyc < 200) begin
            step(1'b0, idle, 1'b1, 1'b0);
            cyc++;
        end
        step(1'b0, idle, 1'b1, 1'b0);
        chk({tag, "_drain"}, 64'(expq.size()), 64'd0);
        chk({tag, "_pv_idle"}, 64'(bus.pix_valid), 64'd0);
        chk({tag, "_frames"}, 64'(frame_count), 64'(16'(mframe)));
        chk({tag, "_errs"}, 64'(err_count), 64'(8'(merr)));
    endtask

    task automatic build_frame(input bit rnd);
        logic [7:0]  bytes[$];
        logic [23:0] p;
        word_t       w;
        fr.delete();
        for (int y = 0; y < YS; y++) begin
            for (int x = 0; x < XS; x++) begin
                p = rnd ? 24'($urandom) : 24'(x + 8 * y);
                bytes.push_back(p[7:0]);
                bytes.push_back(p[15:8]);
                bytes.push_back(p[23:16]);
            end
        end
        for (int i = 0; i < XS * YS * 3 / 4; i++) begin
            w.d = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
            w.u = (i == 0);
            w.l = ((i + 1) % WPL == 0);
            fr.push_back(w);
        end
    endtask

    task automatic push_random_words(input int n);
        word_t w;
        for (int i = 0; i < n; i++) begin
            w.d = $urandom;
            w.u = 1'b0;
            w.l = 1'b0;
            wq.push_back(w);
        end
    endtask

    task automatic reset_pulse(input string tag);
        step(1'b0, idle, 1'b0, 1'b1);
        check_zero(tag);
    endtask

    initial begin
        word_t w;
        model_reset();
        reset_pulse("reset_state");

        // Clean frame, ramp pixels, no back-pressure
        build_frame(1'b0);
        foreach (fr[i]) wq.push_back(fr[i]);
        send(0, 0);
        drain_and_check("ramp");

        // Random pixels with tvalid gaps and 50% pix_ready
        build_frame(1'b1);
        foreach (fr[i]) wq.push_back(fr[i]);
        send(30, 50);
        drain_and_check("backpressure");

        // Words ahead of the first SOF after reset
        reset_pulse("reset_mid");
        push_random_words(5);
        build_frame(1'b1);
        foreach (fr[i]) wq.push_back(fr[i]);
        send(10, 20);
        drain_and_check("presync");

        // Early EOL in the middle of line 1
        build_frame(1'b0);
        for (int i = 0; i < 24; i++) begin
            if (i <= 8 || i >= 12) begin
                w = fr[i];
                if (i == 8) w.l = 1'b1;
                wq.push_back(w);
            end
        end
        send(10, 20);
        drain_and_check("early_eol");

        // SOF arriving at word 14 of a frame
        build_frame(1'b1);
        for (int i = 0; i < 14; i++) wq.push_back(fr[i]);
        foreach (fr[i]) wq.push_back(fr[i]);
        send(20, 30);
        drain_and_check("early_sof");

        // Reset while the phase is PH2, then unsynced data and a clean frame
        build_frame(1'b0);
        wq.push_back(fr[0]);
        wq.push_back(fr[1]);
        send(0, 0);
        reset_pulse("reset_ph2");
        push_random_words(3);
        foreach (fr[i]) wq.push_back(fr[i]);
        send(15, 25);
        drain_and_check("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
